// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor Diff = A - B with Start/Busy/Done handshake
// Optional signed-overflow output Ovf enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Busy,
    output logic             Done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic [WIDTH-2:0]   res_q;
    logic               br_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               bit_d;
    logic               br_d;
    logic [WIDTH-2:0]   res_d;
    logic               last_bit;

    // Single full-subtractor cell operating on the current LSBs.
    assign bit_d    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    assign br_d     = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    // Only WIDTH-1 bits are staged; the final bit goes straight into Diff.
    assign res_d    = (WIDTH-1)'({bit_d, res_q} >> 1);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ovf_d;
    // On the final bit the LSBs of the shift registers are the original operand MSBs.
    assign ovf_d = (a_sr_q[0] ^ b_sr_q[0]) & (bit_d ^ a_sr_q[0]);
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            Diff    <= '0;
            Bout    <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            Ovf     <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        a_sr_q  <= A;
                        b_sr_q  <= B;
                        res_q   <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        Busy    <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_bit) begin
                        Diff    <= {bit_d, res_q};
                        Bout    <= br_d;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        Ovf     <= ovf_d;
`endif
                    end else begin
                        res_q <= res_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
// Table-driven operations plus hand-written sequences for ignore/back-to-back/mid-shift reset.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         Clk;
    logic         Rst_n;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         Busy;
    logic         Done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         Ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Diff  (Diff),
        .Bout  (Bout),
        .Busy  (Busy),
        .Done  (Done)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];
    int   checks;
    int   failures;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_ovf(input string nm, input logic exp);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk(nm, {31'd0, Ovf}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("unreachable %s", nm);
`endif
    endtask

    // Launch one operation, count Busy cycles and edges to Done, then check results.
    task automatic do_op(input vec_t v, input string nm);
        int lat;
        int busy_cnt;
        @(negedge Clk);
        A = v.a; B = v.b; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!Done && lat < 20) begin
            if (Busy) busy_cnt++;
            @(posedge Clk); #1;
            lat++;
        end
        chk({nm, ".latency"}, lat, W);
        chk({nm, ".busy_cycles"}, busy_cnt, W);
        chk({nm, ".diff"}, {24'd0, Diff}, {24'd0, v.diff});
        chk({nm, ".bout"}, {31'd0, Bout}, {31'd0, v.bout});
        chk({nm, ".busy_at_done"}, {31'd0, Busy}, 32'd0);
        check_ovf({nm, ".ovf"}, v.ovf);
        @(posedge Clk); #1;
        chk({nm, ".done_drop"}, {31'd0, Done}, 32'd0);
        chk({nm, ".diff_hold"}, {24'd0, Diff}, {24'd0, v.diff});
    endtask

    initial begin
        int done_cnt;
        int n;
        int first_done;
        checks = 0; failures = 0;
        Rst_n = 1'b0; Start = 1'b0; A = '0; B = '0;

        vecs[0] = '{8'h5A, 8'h1C, 8'h3E, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

        repeat (3) @(posedge Clk);
        #1;
        chk("reset.diff", {24'd0, Diff}, 32'd0);
        chk("reset.bout", {31'd0, Bout}, 32'd0);
        chk("reset.busy", {31'd0, Busy}, 32'd0);
        chk("reset.done", {31'd0, Done}, 32'd0);
        check_ovf("reset.ovf", 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Start re-pulsed with new operands on cycle 3 of Busy is ignored.
        @(negedge Clk);
        A = 8'h5A; B = 8'h1C; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        A = 8'h01; B = 8'h01; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (Done) begin
                done_cnt++;
                chk("ignore.diff", {24'd0, Diff}, 32'h3E);
                chk("ignore.bout", {31'd0, Bout}, 32'd0);
            end
            @(posedge Clk); #1;
        end
        chk("ignore.done_count", done_cnt, 1);
        chk("ignore.idle_busy", {31'd0, Busy}, 32'd0);

        // Start held high: one result every WIDTH+1 edges.
        @(negedge Clk);
        A = 8'h80; B = 8'h01; Start = 1'b1;
        n = 0; first_done = -1; done_cnt = 0;
        while (done_cnt < 3 && n < 60) begin
            @(posedge Clk); #1;
            n++;
            if (Done) begin
                if (done_cnt > 0) chk("b2b.period", n - first_done, W + 1);
                first_done = n;
                done_cnt++;
                chk("b2b.diff", {24'd0, Diff}, 32'h7F);
                chk("b2b.bout", {31'd0, Bout}, 32'd0);
                check_ovf("b2b.ovf", 1'b1);
            end
        end
        chk("b2b.done_count", done_cnt, 3);
        @(posedge Clk); #1;
        chk("b2b.busy_restart", {31'd0, Busy}, 32'd1);
        Start = 1'b0;
        n = 0;
        while ((Busy || Done) && n < 30) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("b2b.drain", {30'd0, Busy, Done}, 32'd0);

        // Reset on SHIFT cycle 4 discards the operation.
        @(negedge Clk);
        A = 8'h10; B = 8'h20; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
        end
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        chk("midrst.diff", {24'd0, Diff}, 32'd0);
        chk("midrst.bout", {31'd0, Bout}, 32'd0);
        chk("midrst.busy", {31'd0, Busy}, 32'd0);
        chk("midrst.done", {31'd0, Done}, 32'd0);
        check_ovf("midrst.ovf", 1'b0);
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (Done || Busy) done_cnt++;
            @(posedge Clk); #1;
        end
        chk("midrst.no_activity", done_cnt, 0);
        do_op(vecs[5], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
